if_id_skid_reg: RTL and testbench

Parametrised fetch/decode stage register with valid/ready handshake, a selectable one-entry skid buffer, synchronous flush and bubble injection. It sits between the instruction fetch unit (instruction memory plus PC) and the decode stage. It generalises the fixed-width write-enable/flush stage register into a backpressure-tolerant stage with configurable instruction and PC widths.

---
 rtl/if_id_skid_reg_pkg.sv | 27 ++
 rtl/if_id_skid_reg_if.sv | 38 +++
 rtl/if_id_skid_reg_stage_entry.sv | 39 +++
 rtl/if_id_skid_reg.sv | 143 ++++++++++++++
 tb/tb_if_id_skid_reg.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/if_id_skid_reg_pkg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg_pkg
// Shared pipeline definitions for the fetch/decode stage register:
//   - default instruction and PC widths
//   - the fill bit of the bubble/NOP encoding (all ones, decode sees a NOP)
//   - the stage-state encoding and a helper mapping state to occupancy
// -----------------------------------------------------------------------------
package if_id_skid_reg_pkg;

    localparam int INST_W_DEF = 32;
    localparam int PC_W_DEF   = 11;

    // Bubble words are built by replicating this bit across the instruction.
    localparam logic NOP_BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    // The state encoding doubles as the number of held entries.
    function automatic logic [1:0] state_occupancy(stage_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/if_id_skid_reg_if.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg_if
// Handshake bundle around the fetch/decode stage register.
//   in_valid/in_ready/in_inst/in_pc     : fetch side (upstream)
//   out_valid/out_ready/out_inst/out_pc : decode side (downstream)
//
// Handshake: a transfer happens on an edge where valid and ready are both
// high. The stage never withdraws out_valid or changes out_inst/out_pc while
// out_valid is high and out_ready is low; flush and reset are the only
// exceptions.
//
// Modports:
//   master : environment around the stage (drives fetch data and out_ready)
//   slave  : the stage register itself
// -----------------------------------------------------------------------------
interface if_id_skid_reg_if #(
    parameter int INST_W = 32,
    parameter int PC_W   = 11
);
    logic              in_valid;
    logic              in_ready;
    logic [INST_W-1:0] in_inst;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_pc;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc
    );
endinterface

// File: rtl/if_id_skid_reg_stage_entry.sv
// -----------------------------------------------------------------------------
// stage_entry
// One held instruction: an INST_W + PC_W register updated on the falling edge.
//   clock       : stage clock (falling edge active)
//   reset       : synchronous, active-high; inst <= BUBBLE, pc <= 0
//   load_bubble : inst <= BUBBLE, pc <= d_pc (wins over load)
//   load        : inst <= d_inst, pc <= d_pc
//   d_inst/d_pc : data to capture
//   q_inst/q_pc : held contents
// -----------------------------------------------------------------------------
module stage_entry #(
    parameter int                INST_W = 32,
    parameter int                PC_W   = 11,
    parameter logic [INST_W-1:0] BUBBLE = {INST_W{1'b1}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              load_bubble,
    input  logic [INST_W-1:0] d_inst,
    input  logic [PC_W-1:0]   d_pc,
    output logic [INST_W-1:0] q_inst,
    output logic [PC_W-1:0]   q_pc
);

    always_ff @(negedge clock) begin
        if (reset) begin
            q_inst <= BUBBLE;
            q_pc   <= '0;
        end else if (load_bubble) begin
            q_inst <= BUBBLE;
            q_pc   <= d_pc;
        end else if (load) begin
            q_inst <= d_inst;
            q_pc   <= d_pc;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg
// Fetch/decode stage register with valid/ready handshake, optional one-entry
// skid buffer, synchronous flush and bubble injection. All state changes on
// the falling edge of clock.
//   clock     : stage clock
//   reset     : synchronous, active-high; beats flush and push
//   flush     : drop every held instruction, present a bubble with pc = in_pc
//   pipe      : slave side of if_id_skid_reg_if (fetch in, decode out)
//   occupancy : held entries 0..2; also the FSM state (EMPTY/ONE/TWO)
//
// SKID = 1: two entries, in_ready registered (no out_ready -> in_ready path).
// SKID = 0: one entry, in_ready = empty | out_ready.
// -----------------------------------------------------------------------------
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter int                INST_W = INST_W_DEF,
    parameter int                PC_W   = PC_W_DEF,
    parameter logic [INST_W-1:0] BUBBLE = {INST_W{NOP_BIT}},
    parameter bit                SKID   = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    if_id_skid_reg_if.slave       pipe,
    output logic [1:0]            occupancy
);

    stage_state_e      state;
    stage_state_e      state_nxt;
    logic              out_valid_q;
    logic [1:0]        occ_q;
    logic              skid_ready_q;

    logic              in_ready_c;
    logic              push;
    logic              pop;
    logic              main_load;
    logic              main_from_skid;
    logic              main_sel_skid;
    logic              skid_load;

    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;

    assign in_ready_c = SKID ? skid_ready_q
                             : ((state == ST_EMPTY) | pipe.out_ready);
    assign push = pipe.in_valid & in_ready_c;
    assign pop  = out_valid_q & pipe.out_ready;

    always_comb begin
        state_nxt      = state;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (push) begin
                    main_load = 1'b1;
                    state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                if (push && pop) begin
                    main_load = 1'b1;
                end else if (push && SKID) begin
                    skid_load = 1'b1;
                    state_nxt = ST_TWO;
                end else if (pop) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a pop can happen.
                if (pop) begin
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Status flags are registered from the next state so the outputs come
    // straight from flops; skid_ready_q is what makes in_ready registered.
    always_ff @(negedge clock) begin
        if (reset || flush) begin
            state        <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            occ_q        <= 2'd0;
            skid_ready_q <= 1'b1;
        end else begin
            state        <= state_nxt;
            out_valid_q  <= (state_nxt != ST_EMPTY);
            occ_q        <= state_occupancy(state_nxt);
            skid_ready_q <= (state_nxt != ST_TWO);
        end
    end

    // On flush the main pc must come from in_pc, never from the skid entry.
    assign main_sel_skid = main_from_skid & ~flush;

    stage_entry #(
        .INST_W (INST_W),
        .PC_W   (PC_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clock       (clock),
        .reset       (reset),
        .load        (main_load),
        .load_bubble (flush),
        .d_inst      (main_sel_skid ? skid_inst : pipe.in_inst),
        .d_pc        (main_sel_skid ? skid_pc   : pipe.in_pc),
        .q_inst      (main_inst),
        .q_pc        (main_pc)
    );

    stage_entry #(
        .INST_W (INST_W),
        .PC_W   (PC_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clock       (clock),
        .reset       (reset),
        .load        (skid_load),
        .load_bubble (1'b0),
        .d_inst      (pipe.in_inst),
        .d_pc        (pipe.in_pc),
        .q_inst      (skid_inst),
        .q_pc        (skid_pc)
    );

    assign pipe.in_ready  = in_ready_c;
    assign pipe.out_valid = out_valid_q;
    assign pipe.out_inst  = out_valid_q ? main_inst : BUBBLE;
    assign pipe.out_pc    = main_pc;
    assign occupancy      = occ_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_reg
// Drives one SKID=1 and one SKID=0 stage register from the same stimulus and
// compares both against a FIFO model of the stage (capacity 2 or 1).
// Inputs change on the rising edge; the DUTs update on the falling edge.
// -----------------------------------------------------------------------------
module tb_if_id_skid_reg;

    localparam int IW = 32;
    localparam int PW = 11;
    localparam logic [IW-1:0] BUB = 32'hFFFF_FFFF;

    // clock / reset
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    always #5 clock = ~clock;

    logic [1:0] occ1, occ0;

    if_id_skid_reg_if #(.INST_W(IW), .PC_W(PW)) p1 ();
    if_id_skid_reg_if #(.INST_W(IW), .PC_W(PW)) p0 ();

    if_id_skid_reg #(.INST_W(IW), .PC_W(PW), .SKID(1'b1)) dut1 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .pipe      (p1.slave),
        .occupancy (occ1)
    );

    if_id_skid_reg #(.INST_W(IW), .PC_W(PW), .SKID(1'b0)) dut0 (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .pipe      (p0.slave),
        .occupancy (occ0)
    );

    // scoreboard: accepted {pc, inst} in acceptance order, head = presented
    logic [PW+IW-1:0] exp_q1[$];
    logic [PW+IW-1:0] exp_q0[$];
    logic [PW-1:0]    hold1 = '0;
    logic [PW-1:0]    hold0 = '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_ready1();
        return exp_q1.size() < 2;
    endfunction

    function automatic logic exp_ready0(input logic ordy);
        return (exp_q0.size() == 0) || ordy;
    endfunction

    task automatic check_outputs();
        check("s1_out_valid", 64'(p1.out_valid), 64'(exp_q1.size() != 0));
        check("s1_out_inst",  64'(p1.out_inst),
              64'((exp_q1.size() != 0) ? exp_q1[0][IW-1:0] : BUB));
        check("s1_out_pc",    64'(p1.out_pc),    64'(hold1));
        check("s1_occupancy", 64'(occ1),         64'(exp_q1.size()));
        check("s0_out_valid", 64'(p0.out_valid), 64'(exp_q0.size() != 0));
        check("s0_out_inst",  64'(p0.out_inst),
              64'((exp_q0.size() != 0) ? exp_q0[0][IW-1:0] : BUB));
        check("s0_out_pc",    64'(p0.out_pc),    64'(hold0));
        check("s0_occupancy", 64'(occ0),         64'(exp_q0.size()));
    endtask

    // One cycle: check held state, drive inputs, check in_ready, advance model.
    task automatic step(input logic rst_i, input logic fl, input logic v,
                        input logic [IW-1:0] inst, input logic [PW-1:0] pc,
                        input logic ordy);
        logic r1, r0;
        @(posedge clock);
        check_outputs();
        reset = rst_i;
        flush = fl;
        p1.in_valid = v;  p1.in_inst = inst;  p1.in_pc = pc;  p1.out_ready = ordy;
        p0.in_valid = v;  p0.in_inst = inst;  p0.in_pc = pc;  p0.out_ready = ordy;
        #1;
        r1 = exp_ready1();
        r0 = exp_ready0(ordy);
        check("s1_in_ready", 64'(p1.in_ready), 64'(r1));
        check("s0_in_ready", 64'(p0.in_ready), 64'(r0));
        @(negedge clock);
        if (rst_i) begin
            exp_q1.delete(); exp_q0.delete();
            hold1 = '0;      hold0 = '0;
        end else if (fl) begin
            exp_q1.delete(); exp_q0.delete();
            hold1 = pc;      hold0 = pc;
        end else begin
            if (exp_q1.size() != 0 && ordy) void'(exp_q1.pop_front());
            if (v && r1) exp_q1.push_back({pc, inst});
            if (exp_q1.size() != 0) hold1 = exp_q1[0][PW+IW-1:IW];
            if (exp_q0.size() != 0 && ordy) void'(exp_q0.pop_front());
            if (v && r0) exp_q0.push_back({pc, inst});
            if (exp_q0.size() != 0) hold0 = exp_q0[0][PW+IW-1:IW];
        end
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, '0, ordy);
    endtask

    initial begin
        p1.in_valid = 1'b0; p1.in_inst = '0; p1.in_pc = '0; p1.out_ready = 1'b0;
        p0.in_valid = 1'b0; p0.in_inst = '0; p0.in_pc = '0; p0.out_ready = 1'b0;

        // reset for two cycles, then check reset values with constants
        repeat (2) @(negedge clock);
        @(posedge clock);
        check("rst_out_valid", 64'(p1.out_valid), 64'd0);
        check("rst_out_inst",  64'(p1.out_inst),  64'hFFFF_FFFF);
        check("rst_out_pc",    64'(p1.out_pc),    64'd0);
        check("rst_in_ready",  64'(p1.in_ready),  64'd1);
        check("rst_occupancy", 64'(occ1),         64'd0);
        check("rst0_in_ready", 64'(p0.in_ready),  64'd1);

        // streaming at full rate
        for (int k = 0; k < 6; k++)
            step(1'b0, 1'b0, 1'b1, 32'h2008_0005 + 32'(k), PW'(k), 1'b1);
        idle(2, 1'b1);

        // stall: A, B absorbed (SKID=1), C held off; then release
        step(1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 11'd4, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 11'd5, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 11'd6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 11'd6, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'hCCCC_0003, 11'd6, 1'b1);
        idle(3, 1'b1);

        // fill to TWO, then flush with a simultaneous push
        step(1'b0, 1'b0, 1'b1, 32'hD0D0_0004, 11'd8, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'hE0E0_0005, 11'd9, 1'b0);
        step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 11'd7, 1'b0);
        idle(3, 1'b1);

        // SKID=0 backpressure: hold one entry, then pop+push at one edge
        step(1'b0, 1'b0, 1'b1, 32'h1111_0006, 11'd10, 1'b0);
        idle(1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h2222_0007, 11'd11, 1'b1);
        idle(2, 1'b1);

        // reset mid-stall in TWO, with flush and push also asserted
        step(1'b0, 1'b0, 1'b1, 32'h3333_0008, 11'd12, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h4444_0009, 11'd13, 1'b0);
        step(1'b1, 1'b1, 1'b1, 32'h5555_000A, 11'd14, 1'b1);
        idle(3, 1'b1);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 1'($urandom_range(0, 1)),
                 $urandom,
                 PW'($urandom_range(0, 2047)),
                 $urandom_range(0, 3) != 0);
        end
        idle(4, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
